// File: rtl/hex_display_scan_if.sv
// hex_display_scan_if: display word/controls from the UI side, panel pins back out
interface hex_display_scan_if #(
    parameter int NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0] disp;
    logic                    dispValid;
    logic                    blank;
    logic                    lzs;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   dig;
    modport master (output disp, dispValid, blank, lzs, input seg, dp, dig);
    modport slave (input disp, dispValid, blank, lzs, output seg, dp, dig);
endinterface

// File: rtl/hex_display_scan.sv
// hex_display_scan: frame-latched multiplexed hex driver for a 7-segment panel
module hex_display_scan #(
    parameter int NUM_DIGITS     = 6,
    parameter int CLK_DIV        = 1000,
    parameter int GHOST_CYCLES   = 50,
    parameter bit SEG_ACTIVE_LOW = 1,
    parameter bit DIG_ACTIVE_LOW = 1
) (
    input logic               clk,
    input logic               rst,
    hex_display_scan_if.slave bus
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GHOST = CW'(GHOST_CYCLES);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);
    localparam logic [111:0] HEX = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    have_data;
    logic                    stale;
    logic                    slot_end;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [3:0]              nib;
    logic                    lit;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   dig_q;
    logic                    dp_q;
    assign slot_end = cnt == CNT_MAX;
    assign frame_end = slot_end && idx == IDX_MAX;
    assign nib = shadow[4*idx +: 4];
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_zero
        assign zero_from[g] = ~|shadow[4*NUM_DIGITS-1:4*g];
    end
    assign lit = !bus.blank && have_data && cnt >= GHOST && !(bus.lzs && idx != '0 && zero_from[idx]);
    // Prescaler, digit index and frame-end latch of the display word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            shadow    <= '0;
            have_data <= 1'b0;
            stale     <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= idx == IDX_MAX ? '0 : idx + 1'b1;
            if (frame_end) begin
                if (bus.dispValid) begin
                    shadow    <= bus.disp;
                    have_data <= 1'b1;
                    stale     <= 1'b0;
                end else begin
                    stale <= have_data;
                end
            end
        end
    end
    // Registered panel drive in active-high form; polarity applied at the pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= '0;
            dig_q <= '0;
            dp_q  <= 1'b0;
        end else begin
            seg_q <= lit ? HEX[7*nib +: 7] : 7'h00;
            dig_q <= lit ? ONE << idx : '0;
            dp_q  <= lit && idx == '0 && stale;
        end
    end
    assign bus.seg = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign bus.dp  = SEG_ACTIVE_LOW ? ~dp_q : dp_q;
    assign bus.dig = DIG_ACTIVE_LOW ? ~dig_q : dig_q;
endmodule

// File: tb/tb_hex_display_scan.sv
// tb_hex_display_scan: directed frame-by-frame checks of the scan driver
module tb_hex_display_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int t, n_cmp, n_bad, d;
    logic [6:0] cs [24];
    logic [5:0] cd [24];
    logic cp [24];
    logic [6:0] es;
    logic [13:0] e, o;

    hex_display_scan_if #(.NUM_DIGITS(6)) bus ();

    hex_display_scan #(
        .NUM_DIGITS(6), .CLK_DIV(4), .GHOST_CYCLES(1),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic capture();
        for (int c = 0; c < 24; c++) begin
            step();
            cs[c] = ~bus.seg;
            cd[c] = ~bus.dig;
            cp[c] = ~bus.dp;
        end
    endtask

    task automatic test_reset();
        bus.disp = 24'h12AB3F;
        bus.dispValid = 1'b1;
        bus.blank = 1'b0;
        bus.lzs = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if ({bus.dig, bus.seg, bus.dp} !== {6'h3F, 7'h7F, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want %h", {bus.dig, bus.seg, bus.dp}, {6'h3F, 7'h7F, 1'b1});
        end
        rst = 1'b0;
        t = 0;
    endtask

    task automatic test_scan();
        logic [41:0] ex [2];
        ex[0] = 42'h0;
        ex[1] = {7'h06, 7'h5B, 7'h77, 7'h7C, 7'h4F, 7'h71};
        for (int f = 0; f < 2; f++) begin
            capture();
            for (int c = 0; c < 24; c++) begin
                d = c / 4;
                es = (c % 4 != 0) ? ex[f][7*d +: 7] : 7'h00;
                e = {es != 0 ? 6'(1 << d) : 6'h00, es, 1'b0};
                o = {cd[c], cs[c], cp[c]};
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL scan f%0d c%0d got %h want %h", f, c, o, e);
                end
            end
        end
    endtask

    task automatic test_tearing();
        logic [41:0] ex [3];
        ex[0] = {7'h06, 7'h5B, 7'h77, 7'h7C, 7'h4F, 7'h71};
        ex[1] = {6{7'h3F}};
        ex[2] = 42'h3F;
        bus.disp = 24'h000000;
        for (int f = 0; f < 3; f++) begin
            capture();
            for (int c = 0; c < 24; c++) begin
                d = c / 4;
                es = (c % 4 != 0) ? ex[f][7*d +: 7] : 7'h00;
                e = {es != 0 ? 6'(1 << d) : 6'h00, es, 1'b0};
                o = {cd[c], cs[c], cp[c]};
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL tearing f%0d c%0d got %h want %h", f, c, o, e);
                end
            end
            if (f == 1)
                bus.lzs = 1'b1;
        end
    endtask

    task automatic test_lzs();
        logic [41:0] ex;
        ex = {7'h00, 7'h00, 7'h00, 7'h77, 7'h3F, 7'h6D};
        bus.disp = 24'h000A05;
        repeat (24) step();
        capture();
        for (int c = 0; c < 24; c++) begin
            d = c / 4;
            es = (c % 4 != 0) ? ex[7*d +: 7] : 7'h00;
            e = {es != 0 ? 6'(1 << d) : 6'h00, es, 1'b0};
            o = {cd[c], cs[c], cp[c]};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL lzs c%0d got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_stale();
        logic exdp [4];
        exdp = '{1'b0, 1'b1, 1'b1, 1'b0};
        bus.disp = 24'h111111;
        repeat (24) step();
        bus.dispValid = 1'b0;
        for (int f = 0; f < 4; f++) begin
            capture();
            for (int c = 0; c < 24; c++) begin
                d = c / 4;
                es = (c % 4 != 0) ? 7'h06 : 7'h00;
                e = {es != 0 ? 6'(1 << d) : 6'h00, es, es != 0 && d == 0 && exdp[f]};
                o = {cd[c], cs[c], cp[c]};
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL stale f%0d c%0d got %h want %h", f, c, o, e);
                end
            end
            if (f == 1)
                bus.dispValid = 1'b1;
        end
    endtask

    task automatic test_blank();
        int c;
        repeat (6) step();
        n_cmp++;
        if ({~bus.dig, ~bus.seg, ~bus.dp} !== {6'h02, 7'h06, 1'b0}) begin
            n_bad++;
            $display("FAIL blank_pre got %h want %h", {~bus.dig, ~bus.seg, ~bus.dp}, {6'h02, 7'h06, 1'b0});
        end
        bus.blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if ({~bus.dig, ~bus.seg, ~bus.dp} !== 14'h0) begin
                n_bad++;
                $display("FAIL blank_dark i%0d got %h want %h", i, {~bus.dig, ~bus.seg, ~bus.dp}, 14'h0);
            end
        end
        bus.blank = 1'b0;
        while (t % 24 != 0) begin
            step();
            c = (t - 1) % 24;
            d = c / 4;
            es = (c % 4 != 0) ? 7'h06 : 7'h00;
            e = {es != 0 ? 6'(1 << d) : 6'h00, es, 1'b0};
            n_cmp++;
            if ({~bus.dig, ~bus.seg, ~bus.dp} !== e) begin
                n_bad++;
                $display("FAIL blank_release c%0d got %h want %h", c, {~bus.dig, ~bus.seg, ~bus.dp}, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [41:0] ex [2];
        ex[0] = 42'h0;
        ex[1] = {6{7'h06}};
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.dig, bus.seg, bus.dp} !== {6'h3F, 7'h7F, 1'b1}) begin
            n_bad++;
            $display("FAIL async_reset got %h want %h", {bus.dig, bus.seg, bus.dp}, {6'h3F, 7'h7F, 1'b1});
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        t = 0;
        for (int f = 0; f < 2; f++) begin
            capture();
            for (int c = 0; c < 24; c++) begin
                d = c / 4;
                es = (c % 4 != 0) ? ex[f][7*d +: 7] : 7'h00;
                e = {es != 0 ? 6'(1 << d) : 6'h00, es, 1'b0};
                o = {cd[c], cs[c], cp[c]};
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL post_reset f%0d c%0d got %h want %h", f, c, o, e);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        t = 0;
        test_reset();
        test_scan();
        test_tearing();
        test_lzs();
        test_stale();
        test_blank();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
Multiplexed driver for the 6-digit common-anode/cathode 7-segment panel. It consumes the 24-bit display word and its valid flag produced by the front-panel UI controller. It latches the word frame-synchronously, then scans one digit per slot with hex decode, anti-ghost dead time and optional leading-zero suppression. It sits between the UI control logic and the panel pins.

Parameters:
NUM_DIGITS, 6, digits scanned; disp width is 4*NUM_DIGITS
CLK_DIV, 1000, clk cycles per digit slot (>=2)
GHOST_CYCLES, 50, cycles at slot start with all digits off (< CLK_DIV)
SEG_ACTIVE_LOW, 1, invert seg and dp outputs
DIG_ACTIVE_LOW, 1, invert dig outputs

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
disp  in  24  hex display word; nibble i shown on digit i, digit 0 rightmost
dispValid  in  1  disp is valid this cycle
blank  in  1  force panel dark
lzs  in  1  leading-zero suppression enable
seg  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point, used as stale indicator
dig  out  6  digit enables, one-hot when lit

Behaviour:
- Single clock, one async active-high reset. Reset values: cnt=0, idx=0, shadow=0, have_data=0, stale=0. Outputs all inactive: seg and dp off, dig all off, honouring the polarity params.
- Prescaler cnt counts 0..CLK_DIV-1 and wraps. At wrap, idx advances; idx wraps from NUM_DIGITS-1 to 0.
- Frame end is idx==NUM_DIGITS-1 and cnt==CLK_DIV-1. At frame end:
  - If dispValid=1: shadow<=disp, have_data<=1, stale<=0.
  - Else: shadow holds, and stale<=have_data.
- shadow never changes mid-frame, so there is no tearing. dispValid outside the frame-end cycle is ignored.
- Outputs are registered. seg/dig/dp in cycle t+1 are a function of cnt, idx, shadow, have_data, stale, blank and lzs in cycle t. This is a 1-cycle latency.
- dig is all off when any of these holds: blank=1, have_data=0, cnt<GHOST_CYCLES, or the current digit is suppressed. Otherwise only dig[idx] is active.
- seg is hex-decoded from shadow[4*idx+3:4*idx], active-high patterns:
  0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- seg is forced off whenever dig is all off.
- Leading-zero suppression: when lzs=1, digit i>=1 is suppressed if nibbles i..NUM_DIGITS-1 of shadow are all zero. Digit 0 is never suppressed, so value 0 shows a single "0".
- dp is lit only when idx==0, stale=1 and digit 0 is lit.
- blank and lzs act combinationally into the output register, i.e. effective next cycle. They do not disturb scan timing.
- Reset mid-frame returns everything to reset values immediately; scan restarts at idx=0, cnt=0.
- SEG_ACTIVE_LOW / DIG_ACTIVE_LOW invert the final outputs only.

Test Plan:
- CLK_DIV=4, GHOST_CYCLES=1. Hold dispValid=1, disp=24'h12AB3F, release reset.
  - Digits dark until first frame end (cycle 23).
  - Then each slot shows 1 dark cycle + 3 lit cycles.
  - Sequence: dig[0] seg=71 (F), dig[1] 4F, dig[2] 7C, dig[3] 77, dig[4] 5B, dig[5] 06.
  - dp off throughout.
- Change disp to 24'h000000 mid-frame with dispValid=1. Old value persists until frame end. Next frame shows 3F on every digit when lzs=0, and only dig[0]=3F when lzs=1.
- lzs=1, disp=24'h000A05. dig[0]=6D, dig[1]=3F, dig[2]=77; digits 3-5 stay dark for their whole slots.
- Latch 24'h111111, then drop dispValid. At the next frame end stale=1: dp lit on digit 0 only, digits still show 06. Reassert dispValid: dp clears after the following frame end.
- Assert blank for 10 cycles mid-scan. dig/seg go off the next cycle. idx/cnt progression is unchanged, checked by dig position after release.
- Assert rst asynchronously mid-slot (between clock edges). Outputs go inactive immediately. After release, dark until a new frame-end latch.
